// File: rtl/dmux4way16_buf.sv
// Registered 4-way demultiplexer: a single valid/ready input stream is routed by sel
// or a round-robin pointer into four one-entry channel buffers, each with its own handshake.
module dmux4way16_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             auto,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             valid_a,
    output logic             valid_b,
    output logic             valid_c,
    output logic             valid_d,
    input  logic             ready_a,
    input  logic             ready_b,
    input  logic             ready_c,
    input  logic             ready_d,
    output logic [1:0]       ptr,
    output logic [15:0]      xfer_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t      state [4];
    logic [WIDTH-1:0] data  [4];
    logic [3:0]       chan_ready;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic [1:0]       dst;
    logic             accept;

    assign chan_ready = {ready_d, ready_c, ready_b, ready_a};

    // A full slot can still take a new word when its consumer drains on the same edge.
    always_comb begin
        dst      = auto ? ptr : sel;
        in_ready = (state[dst] == EMPTY) | chan_ready[dst];
        accept   = in_valid & in_ready;
        load     = '0;
        drain    = '0;
        for (int i = 0; i < 4; i++) begin
            load[i]  = accept && (dst == 2'(i));
            drain[i] = (state[i] == FULL) && chan_ready[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= EMPTY;
                data[i]  <= '0;
            end
            ptr        <= '0;
            xfer_count <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data[i]  <= in;
                    state[i] <= FULL;
                end else if (drain[i]) begin
                    state[i] <= EMPTY;
                end
            end
            if (accept) begin
                xfer_count <= xfer_count + 16'd1;
                if (auto) begin
                    ptr <= ptr + 2'd1;
                end
            end
        end
    end

    assign out_a   = data[0];
    assign out_b   = data[1];
    assign out_c   = data[2];
    assign out_d   = data[3];
    assign valid_a = (state[0] == FULL);
    assign valid_b = (state[1] == FULL);
    assign valid_c = (state[2] == FULL);
    assign valid_d = (state[3] == FULL);

endmodule

// File: tb/tb_dmux4way16_buf.sv
// Self-checking bench for dmux4way16_buf: directed scenarios plus random traffic,
// compared against a behavioural channel/pointer/counter model.
module tb_dmux4way16_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic [1:0]  sel;
    logic        auto;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic        ready_a, ready_b, ready_c, ready_d;
    logic [1:0]  ptr;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_data  [4];
    bit          m_valid [4];
    logic [1:0]  m_ptr;
    logic [15:0] m_count;

    dmux4way16_buf #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .auto(auto),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
        .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
        .ptr(ptr), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check1("out_a", out_a, m_data[0]);
        check1("out_b", out_b, m_data[1]);
        check1("out_c", out_c, m_data[2]);
        check1("out_d", out_d, m_data[3]);
        check1("valid_a", {15'd0, valid_a}, {15'd0, m_valid[0]});
        check1("valid_b", {15'd0, valid_b}, {15'd0, m_valid[1]});
        check1("valid_c", {15'd0, valid_c}, {15'd0, m_valid[2]});
        check1("valid_d", {15'd0, valid_d}, {15'd0, m_valid[3]});
        check1("ptr", {14'd0, ptr}, {14'd0, m_ptr});
        check1("xfer_count", xfer_count, m_count);
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, advance the model, check outputs.
    task automatic applyStimulus(input logic [15:0] word, input logic [1:0] s, input logic a,
                                 input logic v, input logic [3:0] r, input logic rst, input bit chk);
        logic [1:0] d;
        bit         exp_ready;
        bit         acc;
        reset    = rst;
        in       = word;
        sel      = s;
        auto     = a;
        in_valid = v;
        {ready_d, ready_c, ready_b, ready_a} = r;
        #3;
        d         = a ? m_ptr : s;
        exp_ready = !m_valid[d] || r[d];
        acc       = v && exp_ready;
        if (chk) check1("in_ready", {15'd0, in_ready}, {15'd0, exp_ready});
        @(posedge clk);
        if (rst) begin
            for (int x = 0; x < 4; x++) begin
                m_valid[x] = 0;
                m_data[x]  = 16'h0000;
            end
            m_ptr   = 2'd0;
            m_count = 16'd0;
        end else begin
            for (int x = 0; x < 4; x++) begin
                m_valid[x] = (m_valid[x] && !r[x]) || (acc && d == 2'(x));
                if (acc && d == 2'(x)) m_data[x] = word;
            end
            if (acc) m_count = m_count + 16'd1;
            if (acc && a) m_ptr = m_ptr + 2'd1;
        end
        #1;
        if (chk) checkOutput();
    endtask

    initial begin
        reset = 1'b1; in = '0; sel = '0; auto = 1'b0; in_valid = 1'b0;
        {ready_d, ready_c, ready_b, ready_a} = 4'b0000;
        for (int x = 0; x < 4; x++) begin
            m_valid[x] = 0;
            m_data[x]  = 16'h0;
        end
        m_ptr = 2'd0; m_count = 16'd0;
        @(posedge clk); #1;

        // Reset then idle: in_ready high for every sel.
        applyStimulus(16'h0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
        applyStimulus(16'h0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(16'h0, 2'(s), 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
            check1("idle_in_ready", {15'd0, in_ready}, 16'd1);
        end

        // Select routing.
        applyStimulus(16'h1111, 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("sel_out_a", out_a, 16'h1111);
        applyStimulus(16'h2222, 2'd1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("sel_out_b", out_b, 16'h2222);
        applyStimulus(16'h3333, 2'd2, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("sel_out_c", out_c, 16'h3333);
        applyStimulus(16'h4444, 2'd3, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("sel_out_d", out_d, 16'h4444);
        check1("sel_count", xfer_count, 16'd4);
        check1("sel_ptr", {14'd0, ptr}, 16'd0);

        // Round-robin.
        for (int k = 0; k < 5; k++)
            applyStimulus(16'hA000 + 16'(k), 2'd3, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("rr_ptr", {14'd0, ptr}, 16'd1);
        check1("rr_out_a", out_a, 16'hA004);
        check1("rr_out_d", out_d, 16'hA003);

        // Backpressure on b; c unaffected.
        applyStimulus(16'hBEEF, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b1);
        applyStimulus(16'hC0DE, 2'd2, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b1);
        check1("bp_out_c", out_c, 16'hC0DE);
        applyStimulus(16'hCAFE, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b1);
        applyStimulus(16'hCAFE, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b1);
        check1("bp_out_b_held", out_b, 16'hBEEF);
        applyStimulus(16'hCAFE, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        check1("bp_valid_b", {15'd0, valid_b}, 16'd1);
        check1("bp_out_b", out_b, 16'hCAFE);

        // Reset mid-operation.
        applyStimulus(16'h5A5A, 2'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        applyStimulus(16'hD00D, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        applyStimulus(16'h0000, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        check1("rst_valid_a", {15'd0, valid_a}, 16'd0);
        check1("rst_out_d", out_d, 16'h0000);
        check1("rst_count", xfer_count, 16'd0);
        applyStimulus(16'h7777, 2'd2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
        check1("resume_out_a", out_a, 16'h7777);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            applyStimulus(16'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                          4'($urandom), ($urandom_range(0, 60) == 0), 1'b1);

        // Counter wrap.
        applyStimulus(16'h0, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1);
        for (int k = 0; k < 65535; k++)
            applyStimulus(16'(k), 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput();
        check1("wrap_ffff", xfer_count, 16'hFFFF);
        applyStimulus(16'h1234, 2'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        check1("wrap_zero", xfer_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux4way16_buf.md
# dmux4way16_buf

Registered 4-way 16-bit demultiplexer with per-channel one-entry buffers and valid/ready handshakes on every port. It is the distribution counterpart of `mux4way16`: one producer stream is routed to one of four consumer channels, either by explicit select or by a round-robin pointer. It sits between a single word source (e.g. the CPU output bus) and four independent downstream sinks.

## Interface

Parameters:
- `WIDTH`, 16, data word width.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  input data word.
- `sel`  input  2  destination channel; 00=a, 01=b, 10=c, 11=d; ignored when `auto`=1.
- `auto`  input  1  1 = round-robin routing via internal pointer; 0 = route by `sel`.
- `in_valid`  input  1  producer offers `in`.
- `in_ready`  output  1  block accepts `in` this cycle.
- `out_a`, `out_b`, `out_c`, `out_d`  output  WIDTH each  channel buffer contents.
- `valid_a`, `valid_b`, `valid_c`, `valid_d`  output  1 each  channel buffer holds an undelivered word.
- `ready_a`, `ready_b`, `ready_c`, `ready_d`  input  1 each  consumer takes the word this cycle.
- `ptr`  output  2  current round-robin pointer.
- `xfer_count`  output  16  number of accepted input words, mod 2^16.

## Operation

- Destination `dst` = `ptr` if `auto`=1, else `sel`. Combinational from current inputs and state.
- `in_ready` = `~valid_dst | ready_dst` (slot empty, or being drained this cycle). Combinational; `in_ready` does not depend on `in_valid`.
- Accept event: `in_valid & in_ready` at a rising edge. On accept: `out_dst` <= `in`, `valid_dst` <= 1, `xfer_count` <= `xfer_count`+1 (wraps 0xFFFF -> 0x0000).
- Pointer: advances `ptr` <= `ptr`+1 (wraps 11 -> 00) only on an accept with `auto`=1. With `auto`=0 the pointer holds.
- Drain event on channel x: `valid_x & ready_x` at a rising edge. Clears `valid_x` unless the same edge is an accept into x. In that case `valid_x` stays 1 and `out_x` takes the new word. There is no bubble and no loss.
- Channels are independent: any number of channels may drain on the same edge as one accept into any channel.
- `out_x` holds its last value after drain. Consumers must qualify it with `valid_x`.
- A blocked destination (`valid_dst`=1, `ready_dst`=0) stalls the input. Other channels keep draining. In auto mode the pointer does not skip the blocked channel.
- Switching `auto` or `sel` while `in_valid`=1 is legal. Routing uses the values sampled at the accept edge.

## Timing

- Reset (sync, `reset`=1 at edge): all `out_x`=0, all `valid_x`=0, `ptr`=00, `xfer_count`=0.
- During reset, `in_ready` is still evaluated combinationally. Any accept on that edge is discarded. Buffered undelivered words are discarded on a reset mid-operation.
- Latency: a word accepted at edge N is visible on `out_dst` with `valid_dst`=1 after edge N. It can be drained at edge N+1 at the earliest.
- Throughput: one word per cycle sustained, provided the destination is empty or draining each cycle.
- Per-channel state is `{EMPTY, FULL}`:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without an accept.
  - FULL -> FULL on drain with an accept (data replaced), or with no drain.
- Handshake rule: the producer must hold `in` and `in_valid` stable until accepted. `valid_x` never drops without a drain or a reset.

## Test plan

- Reset then idle: after reset, all `valid_x`=0, `out_x`=0x0000, `ptr`=00, `xfer_count`=0, and `in_ready`=1 for any `sel`.
- Select routing, `auto`=0, all `ready_x`=1:
  - Stimulus: send 0x1111/sel=00, 0x2222/01, 0x3333/10, 0x4444/11 on consecutive cycles.
  - Response: each value appears on a, b, c, d respectively one cycle after its accept. `xfer_count`=4 and `ptr` stays 00.
- Round-robin, `auto`=1:
  - Stimulus: send 0xA000..0xA004 back-to-back.
  - Response: channels a, b, c, d, a receive them in that order, and `ptr` reads 01 afterwards.
- Backpressure:
  - Stimulus: `ready_b`=0, `auto`=0. Send 0xBEEF to b, then 0xCAFE to b.
  - Response: `in_ready`=0 while `valid_b`=1. Then raise `ready_b` for one cycle.
    - 0xBEEF drains and 0xCAFE is accepted on the same edge.
    - `valid_b` stays 1 with `out_b`=0xCAFE.
  - Meanwhile, a word sent to c with `ready_c`=1 is unaffected.
- Counter wrap:
  - Stimulus: preload via 65535 accepts, then one more.
  - Response: `xfer_count` goes 0xFFFF -> 0x0000.
- Reset mid-operation:
  - Stimulus: fill a and d with `ready`=0, then assert `reset` for one cycle.
  - Response: `valid_a`=`valid_d`=0, `out_a`=`out_d`=0, `ptr`=00, `xfer_count`=0. Routing resumes correctly afterwards.
